alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Sequential, parametrised successor to the combinational SM83 ALU.
- Executes base arithmetic/logic ops, misc ops (DAA/CPL/SCF/CCF) and CB-extension ops (rotates/shifts/SWAP/BIT/RES/SET) on DATA_W-bit operands.
- Executes wide (multi-byte, e.g. 16-bit ADD HL,rr) ops as SLICES sequential DATA_W-bit passes with carry chaining.
- Sits between the register file and the F register; controlled by the decoder through a start/busy/done handshake.

Parameters:
- DATA_W, 8, slice width in bits; even, >= 8.
- SLICES, 2, slices per wide op; >= 1. Full operand width W = DATA_W*SLICES.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- mode  in  2  operation class: 00 base, 01 misc, 10 ext shift, 11 ext bit.
- op  in  3  operation code within mode. Base: ADD,ADC,SUB,SBC,AND,XOR,OR,CP = 0..7. Misc op[1:0]: DAA,CPL,SCF,CCF. Ext shift: RLC,RRC,RL,RR,SLA,SRA,SWAP,SRL = 0..7. Ext bit op[1:0]: 01 BIT, 10 RES, 11 SET; 00 is a no-op.
- bit_sel  in  3  bit index for BIT/RES/SET.
- wide  in  1  1 = W-bit op over SLICES passes; honoured for mode 00 only.
- a_data  in  W  destination/accumulator operand.
- b_data  in  W  source operand.
- flags_in  in  4  current F as {Z,N,H,C}.
- busy  out  1  high while an op is in flight, including the DONE cycle.
- done  out  1  one-cycle pulse; res/flags valid from this cycle.
- res  out  W  result.
- flags  out  4  result flags {Z,N,H,C}.

Behaviour:
- Reset (async, any state, including mid-op): state=IDLE; busy=0, done=0, res=0, flags=0. The aborted op never pulses done.
- FSM states:
  - IDLE: on start, latch all inputs, slice index=0, carry=(op ADC/SBC ? flags_in.C : 0), go to EXEC. In IDLE, busy=0.
  - EXEC: each cycle computes slice[idx] into an internal accumulator and chains carry/borrow. After the last slice (idx=SLICES-1 if wide, else 0), go to DONE.
  - DONE: res/flags registers are updated on entry; done=1, busy=1 for this one cycle; then IDLE.
- Latency (start sampled at edge 0): narrow ops pulse done in cycle 2; wide ops in cycle SLICES+1.
- start while busy=1 is ignored; no queueing.
- res/flags hold their value until the next DONE.
- Base flags (narrow):
  - Z = (res[DATA_W-1:0]==0).
  - N = 1 for SUB/SBC/CP.
  - H = carry/borrow out of bit DATA_W/2-1.
  - C = carry/borrow out of bit DATA_W-1.
  - AND: H=1, C=0. XOR/OR: H=0, C=0.
  - CP: computes flags as SUB; res=a_data.
- Base wide:
  - Carry chains between slices.
  - H = out of bit W-DATA_W/2-1; C = out of bit W-1.
  - Z = flags_in.Z (preserved).
  - N = 1 for SUB/SBC/CP, else 0.
  - Logic ops are applied per slice.
- Mode 01/10/11 with wide=1: treated as narrow. These modes operate on a_data[DATA_W-1:0]; res upper bits are 0.
- Misc:
  - DAA: standard SM83 adjust using flags_in N/H/C; Z from result, H=0, N kept. For DATA_W != 8, DAA gives res=a, flags=flags_in.
  - CPL: res=~a; N=1, H=1; Z and C kept.
  - SCF: res=a; C=1, N=0, H=0; Z kept.
  - CCF: res=a; C=~flags_in.C, N=0, H=0; Z kept.
- Ext shift:
  - C = bit shifted out; Z from result; N=0, H=0.
  - RL/RR shift in flags_in.C; SRA keeps the MSB.
  - SWAP exchanges nibbles (DATA_W/2 halves); C=0.
- Ext bit:
  - bit_sel is taken modulo DATA_W.
  - BIT: res=a; Z=~a[bit]; N=0, H=1; C kept.
  - RES/SET: clear/set the bit; flags=flags_in.
  - op[1:0]=00: res=a, flags=flags_in.

Optional Feature:
- Macro ALU_SEQ_FASTNARROW_EN.
- Defined: a narrow op is computed combinationally from the inputs at the start edge and goes IDLE->DONE directly, so done pulses in cycle 1. Wide ops are unchanged.
- Undefined: all ops pass through EXEC; latencies as above.

Test Plan:
- Reset: assert rst mid-wide-op (cycle 1 of EXEC) -> busy=0, done=0, res=0, flags=0 immediately; no done after release.
- Narrow ADD: a=0x3A, b=0xC6 -> res=0x00, flags=1011 (Z,H,C); done in cycle 2, busy high cycles 1-2.
- Narrow SBC: a=0x10, b=0x01, C_in=1 -> res=0x0E, flags=0110 (N,H); CP with a=0x10, b=0x10 -> res=0x10, flags=1100.
- Wide ADD (SLICES=2): a=0x0FFF, b=0x0001, flags_in.Z=1 -> res=0x1000, flags=1010 (Z preserved, H from bit 11); done in cycle 3.
- Ext: RL a=0x80, C_in=0 -> res=0x00, flags=1001; SWAP 0xF1 -> 0x1F, flags=0000; BIT 7 on 0x7F -> Z=1, H=1, C kept.
- Handshake: start held high across busy -> exactly one op executes, single done pulse, second op accepted only in the IDLE cycle after DONE.

Source files
------------

// File: rtl/alu_seq_if.sv
// Decoder <-> ALU handshake and operand bus for alu_seq.
// The decoder side uses the master modport and the ALU uses the slave modport.
interface alu_seq_if #(
  parameter int DATA_W = 8,
  parameter int SLICES = 2
);
  localparam int W = DATA_W * SLICES;

  logic         start;
  logic [1:0]   mode;
  logic [2:0]   op;
  logic [2:0]   bit_sel;
  logic         wide;
  logic [W-1:0] a_data;
  logic [W-1:0] b_data;
  logic [3:0]   flags_in;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic [3:0]   flags;

  modport master (
    output start, mode, op, bit_sel, wide, a_data, b_data, flags_in,
    input  busy, done, res, flags
  );

  modport slave (
    input  start, mode, op, bit_sel, wide, a_data, b_data, flags_in,
    output busy, done, res, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential SM83-style ALU: narrow ops in one EXEC pass, wide base ops over SLICES passes.
// Optional macro ALU_SEQ_FASTNARROW_EN computes narrow ops at the start edge (IDLE -> DONE).
module alu_seq #(
  parameter int DATA_W = 8,
  parameter int SLICES = 2
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int W    = DATA_W * SLICES;
  localparam int HW   = DATA_W / 2;
  localparam int IDXW = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t state_q, state_d;

  logic [1:0]      mode_q;
  logic [2:0]      op_q;
  logic [2:0]      bit_q;
  logic            wide_q;
  logic [W-1:0]    a_q, b_q, acc_q;
  logic [3:0]      fin_q;
  logic [IDXW-1:0] idx_q;
  logic            carry_q;
  logic [W-1:0]    res_q, res_d;
  logic [3:0]      flags_q, flags_d;

  logic               load, upd, wide_eff, last_slice, n_op;
  logic [DATA_W-1:0]  slice_a, slice_b;
  logic [DATA_W+1:0]  sl;
  logic [DATA_W+3:0]  nr;
  logic [W-1:0]       wide_res;

  // Returns {carry_out, half_carry_out, result}; subtract ops return the difference (CP too).
  function automatic logic [DATA_W+1:0] base_slice(input logic [2:0] op, input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b, input logic cin);
    logic [DATA_W:0] full;
    logic [HW:0]     half;
    logic            h;
    full = '0;
    half = '0;
    h    = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        full = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
        half = {1'b0, a[HW-1:0]} + {1'b0, b[HW-1:0]} + {{HW{1'b0}}, cin};
        h    = half[HW];
      end
      3'd2, 3'd3, 3'd7: begin
        full = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, cin};
        half = {1'b0, a[HW-1:0]} - {1'b0, b[HW-1:0]} - {{HW{1'b0}}, cin};
        h    = half[HW];
      end
      3'd4: begin
        full = {1'b0, a & b};
        h    = 1'b1;
      end
      3'd5:    full = {1'b0, a ^ b};
      default: full = {1'b0, a | b};
    endcase
    return {full[DATA_W], h, full[DATA_W-1:0]};
  endfunction

  // Full narrow operation; returns {flags, result}.
  function automatic logic [DATA_W+3:0] narrow_calc(input logic [1:0] mode, input logic [2:0] op,
                                                    input logic [2:0] bsel, input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b, input logic [3:0] fin);
    logic [DATA_W+1:0] s;
    logic [DATA_W-1:0] r, adj;
    logic [3:0]        f;
    logic              c;
    r   = a;
    f   = fin;
    adj = '0;
    c   = 1'b0;
    s   = '0;
    case (mode)
      2'b00: begin
        s = base_slice(op, a, b, (op == 3'd1 || op == 3'd3) ? fin[0] : 1'b0);
        r = (op == 3'd7) ? a : s[DATA_W-1:0];
        f = {s[DATA_W-1:0] == '0, op == 3'd2 || op == 3'd3 || op == 3'd7, s[DATA_W], s[DATA_W+1]};
      end
      2'b01: begin
        case (op[1:0])
          2'd0: begin
            if (DATA_W == 8) begin
              c = fin[0];
              if (!fin[2]) begin
                if (fin[0] || a > DATA_W'(9'h099)) begin
                  adj = adj | DATA_W'(8'h60);
                  c   = 1'b1;
                end
                if (fin[1] || a[3:0] > 4'h9) adj = adj | DATA_W'(8'h06);
                r = a + adj;
              end else begin
                if (fin[0]) adj = adj | DATA_W'(8'h60);
                if (fin[1]) adj = adj | DATA_W'(8'h06);
                r = a - adj;
              end
              f = {r == '0, fin[2], 1'b0, c};
            end
          end
          2'd1: begin
            r = ~a;
            f = {fin[3], 1'b1, 1'b1, fin[0]};
          end
          2'd2:    f = {fin[3], 1'b0, 1'b0, 1'b1};
          default: f = {fin[3], 1'b0, 1'b0, ~fin[0]};
        endcase
      end
      2'b10: begin
        case (op)
          3'd0: begin r = {a[DATA_W-2:0], a[DATA_W-1]}; c = a[DATA_W-1]; end
          3'd1: begin r = {a[0], a[DATA_W-1:1]};        c = a[0];        end
          3'd2: begin r = {a[DATA_W-2:0], fin[0]};      c = a[DATA_W-1]; end
          3'd3: begin r = {fin[0], a[DATA_W-1:1]};      c = a[0];        end
          3'd4: begin r = {a[DATA_W-2:0], 1'b0};        c = a[DATA_W-1]; end
          3'd5: begin r = {a[DATA_W-1], a[DATA_W-1:1]}; c = a[0];        end
          3'd6: begin r = {a[HW-1:0], a[DATA_W-1:HW]};  c = 1'b0;        end
          default: begin r = {1'b0, a[DATA_W-1:1]};     c = a[0];        end
        endcase
        f = {r == '0, 1'b0, 1'b0, c};
      end
      default: begin
        // bit_sel is 3 bits and DATA_W >= 8, so the modulo is the identity.
        case (op[1:0])
          2'b01:   f = {~a[bsel], 1'b0, 1'b1, fin[0]};
          2'b10:   r[bsel] = 1'b0;
          2'b11:   r[bsel] = 1'b1;
          default: r = a;
        endcase
      end
    endcase
    return {f, r};
  endfunction

  assign wide_eff   = wide_q && (mode_q == 2'b00);
  assign last_slice = (idx_q == IDXW'(SLICES - 1));
  assign n_op       = (op_q == 3'd2) || (op_q == 3'd3) || (op_q == 3'd7);
  assign slice_a    = a_q[idx_q*DATA_W +: DATA_W];
  assign slice_b    = b_q[idx_q*DATA_W +: DATA_W];
  assign sl         = base_slice(op_q, slice_a, slice_b, carry_q);
  assign nr         = narrow_calc(mode_q, op_q, bit_q, a_q[DATA_W-1:0], b_q[DATA_W-1:0], fin_q);

  always_comb begin
    wide_res = acc_q;
    wide_res[idx_q*DATA_W +: DATA_W] = (op_q == 3'd7) ? slice_a : sl[DATA_W-1:0];
  end

`ifdef ALU_SEQ_FASTNARROW_EN
  logic [DATA_W+3:0] fast_nr;
  assign fast_nr = narrow_calc(bus.mode, bus.op, bus.bit_sel, bus.a_data[DATA_W-1:0],
                               bus.b_data[DATA_W-1:0], bus.flags_in);
`endif

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    upd     = 1'b0;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = S_EXEC;
`ifdef ALU_SEQ_FASTNARROW_EN
          if (!(bus.wide && bus.mode == 2'b00)) begin
            state_d = S_DONE;
            upd     = 1'b1;
            res_d   = W'(fast_nr[DATA_W-1:0]);
            flags_d = fast_nr[DATA_W+3:DATA_W];
          end
`endif
        end
      end
      S_EXEC: begin
        if (!wide_eff) begin
          state_d = S_DONE;
          upd     = 1'b1;
          res_d   = W'(nr[DATA_W-1:0]);
          flags_d = nr[DATA_W+3:DATA_W];
        end else if (last_slice) begin
          state_d = S_DONE;
          upd     = 1'b1;
          res_d   = wide_res;
          flags_d = {fin_q[3], n_op, sl[DATA_W], sl[DATA_W+1]};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= '0;
      op_q    <= '0;
      bit_q   <= '0;
      wide_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      fin_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      if (load) begin
        mode_q  <= bus.mode;
        op_q    <= bus.op;
        bit_q   <= bus.bit_sel;
        wide_q  <= bus.wide;
        a_q     <= bus.a_data;
        b_q     <= bus.b_data;
        fin_q   <= bus.flags_in;
        idx_q   <= '0;
        carry_q <= (bus.mode == 2'b00 && (bus.op == 3'd1 || bus.op == 3'd3)) ? bus.flags_in[0] : 1'b0;
        acc_q   <= '0;
      end else if (state_q == S_EXEC) begin
        acc_q   <= wide_res;
        carry_q <= sl[DATA_W+1];
        idx_q   <= idx_q + IDXW'(1);
      end
      if (upd) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = (state_q == S_DONE);
  assign bus.res   = res_q;
  assign bus.flags = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed + randomized bench for alu_seq, checked against an integer-arithmetic model.
module tb_alu_seq;
  localparam int DATA_W = 8;
  localparam int SLICES = 2;
  localparam int W      = DATA_W * SLICES;
`ifdef ALU_SEQ_FASTNARROW_EN
  localparam int NLAT = 1;
`else
  localparam int NLAT = 2;
`endif
  localparam int WLAT = SLICES + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.DATA_W(DATA_W), .SLICES(SLICES)) bus();
  alu_seq #(.DATA_W(DATA_W), .SLICES(SLICES)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: whole-operand integer arithmetic; returns {flags, res}.
  function automatic logic [W+3:0] model(input logic [1:0] m, input logic [2:0] o, input logic [2:0] bs,
                                         input logic wd, input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] fi);
    int n, mask, lm, av, bv, cin, full, half, r, msb, lsb, ci, k;
    logic z, nf, h, c;
    logic [W-1:0] rr;
    logic [3:0] f;
    bit is_wide;
    is_wide = wd && (m == 2'b00);
    n    = is_wide ? W : DATA_W;
    mask = (1 << n) - 1;
    lm   = (1 << (n - DATA_W / 2)) - 1;
    av   = int'(a) & mask;
    bv   = int'(b) & mask;
    cin  = (o == 3'd1 || o == 3'd3) ? int'(fi[0]) : 0;
    msb  = (av >> (n - 1)) & 1;
    lsb  = av & 1;
    ci   = int'(fi[0]);
    r = av; f = fi; h = 0; c = 0;
    case (m)
      2'b00: begin
        if (o <= 3'd1) begin
          full = av + bv + cin; half = (av & lm) + (bv & lm) + cin;
          c = full > mask; h = half > lm; r = full & mask;
        end else if (o == 3'd2 || o == 3'd3 || o == 3'd7) begin
          full = av - bv - cin; half = (av & lm) - (bv & lm) - cin;
          c = full < 0; h = half < 0; r = full & mask;
        end else if (o == 3'd4) begin r = av & bv; h = 1; end
        else if (o == 3'd5) r = av ^ bv;
        else r = av | bv;
        nf = (o == 3'd2 || o == 3'd3 || o == 3'd7);
        z  = is_wide ? fi[3] : (r == 0);
        if (o == 3'd7) r = av;
        f = {z, nf, h, c};
      end
      2'b01: begin
        case (o[1:0])
          2'd0: begin
            c = fi[0];
            if (!fi[2]) begin
              if (fi[0] || av > 'h99) begin r = r + 'h60; c = 1; end
              if (fi[1] || (r & 'hF) > 9) r = r + 6;
            end else begin
              if (fi[0]) r = r - 'h60;
              if (fi[1]) r = r - 6;
            end
            r = r & mask;
            f = {r == 0, fi[2], 1'b0, c};
          end
          2'd1: begin r = ~av & mask; f = {fi[3], 1'b1, 1'b1, fi[0]}; end
          2'd2: f = {fi[3], 1'b0, 1'b0, 1'b1};
          default: f = {fi[3], 1'b0, 1'b0, ~fi[0]};
        endcase
      end
      2'b10: begin
        case (o)
          3'd0: begin r = ((av << 1) | msb) & mask;     c = msb; end
          3'd1: begin r = (av >> 1) | (lsb << (n - 1)); c = lsb; end
          3'd2: begin r = ((av << 1) | ci) & mask;      c = msb; end
          3'd3: begin r = (av >> 1) | (ci << (n - 1));  c = lsb; end
          3'd4: begin r = (av << 1) & mask;             c = msb; end
          3'd5: begin r = (av >> 1) | (msb << (n - 1)); c = lsb; end
          3'd6: begin r = ((av << (n / 2)) & mask) | (av >> (n / 2)); c = 0; end
          default: begin r = av >> 1;                   c = lsb; end
        endcase
        f = {r == 0, 1'b0, 1'b0, c};
      end
      default: begin
        k = int'(bs) % DATA_W;
        case (o[1:0])
          2'b01: f = {((av >> k) & 1) == 0, 1'b0, 1'b1, fi[0]};
          2'b10: r = av & ~(1 << k);
          2'b11: r = av | (1 << k);
          default: r = av;
        endcase
      end
    endcase
    rr = r[W-1:0];
    return {f, rr};
  endfunction

  task automatic run_op(input string tag, input logic [1:0] m, input logic [2:0] o, input logic [2:0] bs,
                        input logic wd, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] fi, input logic [W-1:0] er, input logic [3:0] ef);
    int cyc, el;
    bit seen;
    el = (wd && m == 2'b00) ? WLAT : NLAT;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.op = o; bus.bit_sel = bs;
    bus.wide = wd; bus.a_data = a; bus.b_data = b; bus.flags_in = fi;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; seen = 0;
    while (!seen && cyc <= 20) begin
      if (bus.done === 1'b1) seen = 1;
      else begin
        chk({tag, " busy_exec"}, 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({tag, " latency"}, seen ? 32'(cyc) : 32'd0, 32'(el));
    chk({tag, " res"}, 32'(bus.res), 32'(er));
    chk({tag, " flags"}, 32'(bus.flags), 32'(ef));
    chk({tag, " busy_done"}, 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk({tag, " done_clear"}, 32'(bus.done), 32'd0);
    chk({tag, " busy_clear"}, 32'(bus.busy), 32'd0);
    $display("op %s mode=%0d op=%0d wide=%0d a=%h b=%h fin=%b res=%h flags=%b lat=%0d",
             tag, m, o, wd, a, b, fi, bus.res, bus.flags, cyc);
  endtask

  task automatic run_rand(input string tag, input logic [1:0] m, input logic [2:0] o, input logic [2:0] bs,
                          input logic wd, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fi);
    logic [W+3:0] e;
    e = model(m, o, bs, wd, a, b, fi);
    run_op(tag, m, o, bs, wd, a, b, fi, e[W-1:0], e[W+3:W]);
  endtask

  initial begin
    logic [W+3:0] ea, eb;
    int done_cnt;
    bus.start = 1'b0; bus.mode = '0; bus.op = '0; bus.bit_sel = '0;
    bus.wide = 1'b0; bus.a_data = '0; bus.b_data = '0; bus.flags_in = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset res", 32'(bus.res), 32'd0);
    chk("reset flags", 32'(bus.flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_narrow", 2'b00, 3'd0, 3'd0, 1'b0, 16'h003A, 16'h00C6, 4'b0000, 16'h0000, 4'b1011);
    run_op("sbc_narrow", 2'b00, 3'd3, 3'd0, 1'b0, 16'h0010, 16'h0001, 4'b0001, 16'h000E, 4'b0110);
    run_op("cp_narrow",  2'b00, 3'd7, 3'd0, 1'b0, 16'h0010, 16'h0010, 4'b0000, 16'h0010, 4'b1100);
    run_op("add_wide",   2'b00, 3'd0, 3'd0, 1'b1, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010);
    run_op("rl",         2'b10, 3'd2, 3'd0, 1'b0, 16'h0080, 16'h0000, 4'b0000, 16'h0000, 4'b1001);
    run_op("swap",       2'b10, 3'd6, 3'd0, 1'b0, 16'h00F1, 16'h0000, 4'b0000, 16'h001F, 4'b0000);
    run_op("bit7",       2'b11, 3'd1, 3'd7, 1'b0, 16'h007F, 16'h0000, 4'b0001, 16'h007F, 4'b1011);
    run_op("sbc_wide",   2'b00, 3'd3, 3'd0, 1'b1, 16'h1000, 16'h0000, 4'b0001, 16'h0FFF, 4'b0110);

    // Async reset one cycle into a wide op.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b00; bus.op = 3'd0; bus.wide = 1'b1;
    bus.a_data = 16'h1234; bus.b_data = 16'h1111; bus.flags_in = 4'b0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("rst_mid busy_before", 32'(bus.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid busy", 32'(bus.busy), 32'd0);
    chk("rst_mid done", 32'(bus.done), 32'd0);
    chk("rst_mid res", 32'(bus.res), 32'd0);
    chk("rst_mid flags", 32'(bus.flags), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) done_cnt++;
    end
    chk("rst_mid no_done", 32'(done_cnt), 32'd0);
    $display("op rst_mid aborted wide add, done pulses after release=%0d", done_cnt);

    // start held high across busy: op A, then op B accepted in the IDLE cycle after DONE.
    ea = model(2'b00, 3'd0, 3'd0, 1'b0, 16'h0055, 16'h0011, 4'b0000);
    eb = model(2'b00, 3'd5, 3'd0, 1'b0, 16'h00F0, 16'h003C, 4'b0000);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 2'b00; bus.op = 3'd0; bus.wide = 1'b0;
    bus.a_data = 16'h0055; bus.b_data = 16'h0011; bus.flags_in = 4'b0000;
    @(posedge clk); #1;
    bus.op = 3'd5; bus.a_data = 16'h00F0; bus.b_data = 16'h003C;
    for (int c = 1; c <= 2 * NLAT + 1; c++) begin
      chk($sformatf("hs busy c%0d", c), 32'(bus.busy), (c == NLAT + 1) ? 32'd0 : 32'd1);
      chk($sformatf("hs done c%0d", c), 32'(bus.done), (c == NLAT || c == 2 * NLAT + 1) ? 32'd1 : 32'd0);
      if (c == NLAT) chk("hs res_a", 32'(bus.res), 32'(ea[W-1:0]));
      if (c == 2 * NLAT + 1) chk("hs res_b", 32'(bus.res), 32'(eb[W-1:0]));
      if (c == 2 * NLAT + 1) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    chk("hs idle_after", 32'(bus.busy), 32'd0);
    $display("op handshake held start, res=%h flags=%b", bus.res, bus.flags);

    for (int i = 0; i < 150; i++) begin
      run_rand($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom),
               1'($urandom), W'($urandom), W'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
